// File: rtl/bcd_adder_serial_ndigit.sv
// Digit-serial multi-digit BCD adder/subtractor: one decimal digit per clock, LSD first,
// with a registered decimal carry between digits. Subtract adds the 9's complement of y.
module bcd_adder_serial_ndigit #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  op,
  input  logic [4*DIGITS-1:0]   x,
  input  logic [4*DIGITS-1:0]   y,
  input  logic                  c_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   s,
  output logic                  c_out,
  output logic                  invalid
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [4:0] LAST = 5'(DIGITS - 1);

  logic [1:0]          state;
  logic [4:0]          cnt;
  logic                carry;
  logic                op_r;
  logic [4*DIGITS-1:0] x_r;
  logic [4*DIGITS-1:0] y_r;

  logic [3:0] a_d;
  logic [3:0] y_d;
  logic [3:0] b_d;
  logic [4:0] res_d;

  // One decimal digit: binary add, then +6 correction when the sum leaves 0..9.
  function automatic logic [4:0] bcd_digit_add(input logic [3:0] a, input logic [3:0] b,
                                               input logic cin);
    logic [4:0] z;
    z = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    if (z > 5'd9) bcd_digit_add = {1'b1, z[3:0] + 4'd6};
    else          bcd_digit_add = {1'b0, z[3:0]};
  endfunction

  function automatic logic any_non_bcd(input logic [4*DIGITS-1:0] v);
    any_non_bcd = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) any_non_bcd = 1'b1;
  endfunction

  always_comb begin
    a_d = 4'd0;
    y_d = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt == 5'(i)) begin
        a_d = x_r[4*i +: 4];
        y_d = y_r[4*i +: 4];
      end
    end
    b_d   = op_r ? (4'd9 - y_d) : y_d;
    res_d = bcd_digit_add(a_d, b_d, carry);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= 5'd0;
      carry   <= 1'b0;
      op_r    <= 1'b0;
      x_r     <= '0;
      y_r     <= '0;
      s       <= '0;
      c_out   <= 1'b0;
      invalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x_r     <= x;
            y_r     <= y;
            op_r    <= op;
            carry   <= op ? ~c_in : c_in;
            cnt     <= 5'd0;
            s       <= '0;
            c_out   <= 1'b0;
            invalid <= any_non_bcd(x) | any_non_bcd(y);
            state   <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < DIGITS; i++)
            if (cnt == 5'(i)) s[4*i +: 4] <= res_d[3:0];
          carry <= res_d[4];
          cnt   <= cnt + 5'd1;
          // Final carry becomes c_out; for subtract a missing carry means a borrow.
          if (cnt == LAST) begin
            c_out <= op_r ? ~res_d[4] : res_d[4];
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_bcd_adder_serial_ndigit.sv
// Bench for the serial BCD adder: three instances (1, 4 and 8 digits) on one clock and reset,
// checked against an integer-arithmetic model of decimal add/subtract.
module tb_bcd_adder_serial_ndigit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  start_v = 3'b000;
  logic        op = 1'b0;
  logic        c_in = 1'b0;
  logic [31:0] xb = 32'h0;
  logic [31:0] yb = 32'h0;

  logic        busy1, done1, cout1, inv1;
  logic [3:0]  s1;
  logic        busy4, done4, cout4, inv4;
  logic [15:0] s4;
  logic        busy8, done8, cout8, inv8;
  logic [31:0] s8;

  int          sel = 4;
  logic        busy_m, done_m, cout_m, inv_m;
  logic [31:0] s_m;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bcd_adder_serial_ndigit #(.DIGITS(1)) u_d1 (
    .clk(clk), .reset_n(reset_n), .start(start_v[0]), .op(op), .x(xb[3:0]), .y(yb[3:0]),
    .c_in(c_in), .busy(busy1), .done(done1), .s(s1), .c_out(cout1), .invalid(inv1));
  bcd_adder_serial_ndigit #(.DIGITS(4)) u_d4 (
    .clk(clk), .reset_n(reset_n), .start(start_v[1]), .op(op), .x(xb[15:0]), .y(yb[15:0]),
    .c_in(c_in), .busy(busy4), .done(done4), .s(s4), .c_out(cout4), .invalid(inv4));
  bcd_adder_serial_ndigit #(.DIGITS(8)) u_d8 (
    .clk(clk), .reset_n(reset_n), .start(start_v[2]), .op(op), .x(xb), .y(yb),
    .c_in(c_in), .busy(busy8), .done(done8), .s(s8), .c_out(cout8), .invalid(inv8));

  always_comb begin
    busy_m = busy4; done_m = done4; cout_m = cout4; inv_m = inv4; s_m = {16'h0, s4};
    if (sel == 1) begin
      busy_m = busy1; done_m = done1; cout_m = cout1; inv_m = inv1; s_m = {28'h0, s1};
    end else if (sel == 8) begin
      busy_m = busy8; done_m = done8; cout_m = cout8; inv_m = inv8; s_m = s8;
    end
  end

  function automatic logic [2:0] strb(input int d);
    strb = (d == 1) ? 3'b001 : (d == 8) ? 3'b100 : 3'b010;
  endfunction

  // Reference: operands as decimal integers, result modulo 10^d.
  function automatic void model(input int d, input logic [31:0] xv, input logic [31:0] yv,
                                input logic opv, input logic cv, output logic [31:0] s_e,
                                output logic c_e, output logic inv_e);
    longint xi, yi, m, r;
    logic [31:0] xt, yt;
    xi = 0; yi = 0; m = 1; inv_e = 1'b0; xt = xv; yt = yv;
    for (int i = d - 1; i >= 0; i--) begin
      xi = xi * 10 + longint'(xt[4*i +: 4]);
      yi = yi * 10 + longint'(yt[4*i +: 4]);
      if (xt[4*i +: 4] > 4'd9 || yt[4*i +: 4] > 4'd9) inv_e = 1'b1;
      m = m * 10;
    end
    if (!opv) begin
      r = xi + yi + longint'(cv);
      c_e = (r >= m);
      if (c_e) r = r - m;
    end else begin
      r = xi - yi - longint'(cv);
      c_e = (r < 0);
      if (c_e) r = r + m;
    end
    s_e = 32'h0;
    for (int i = 0; i < d; i++) begin
      s_e[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
  endfunction

  function automatic logic [31:0] rand_bcd(input int d);
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < d; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // Drives one start pulse and collects the outcome; lat counts negedges from E0 to done.
  task automatic run_op(input int d, input logic [31:0] xv, input logic [31:0] yv,
                        input logic opv, input logic cv, output logic [31:0] s_o,
                        output logic co, output logic inv, output int lat, output int bcnt,
                        output logic bdone, output logic [31:0] s_e0);
    sel = d;
    bdone = 1'b0;
    @(negedge clk);
    xb = xv; yb = yv; op = opv; c_in = cv; start_v = strb(d);
    @(posedge clk);
    #1;
    start_v = 3'b000;
    s_e0 = s_m;
    lat = 0; bcnt = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (done_m) begin
        bdone = busy_m;
        break;
      end
      if (busy_m) bcnt++;
    end
    s_o = s_m; co = cout_m; inv = inv_m;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy4); end
    total++; if (done4 !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done4); end
    total++; if (s4 !== 16'h0) begin bad++; $display("FAIL reset_s: got %h want 0000", s4); end
    total++; if (cout4 !== 1'b0) begin bad++; $display("FAIL reset_cout: got %b want 0", cout4); end
    total++; if (inv4 !== 1'b0) begin bad++; $display("FAIL reset_invalid: got %b want 0", inv4); end
    total++; if ({s1, s8} !== 36'h0) begin bad++; $display("FAIL reset_s_other: got %h %h want 0", s1, s8); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [15:0] dx [6] = '{16'h0999, 16'h9999, 16'h4567, 16'h0100, 16'h0001, 16'h0050};
    logic [15:0] dy [6] = '{16'h0001, 16'h0001, 16'h5432, 16'h0001, 16'h0002, 16'h0050};
    logic        dop[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        dci[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] ds [6] = '{16'h1000, 16'h0000, 16'h0000, 16'h0099, 16'h9999, 16'h9999};
    logic        dc [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] so, se0;
    logic co, inv, bd;
    int lat, bc;
    for (int k = 0; k < 6; k++) begin
      run_op(4, {16'h0, dx[k]}, {16'h0, dy[k]}, dop[k], dci[k], so, co, inv, lat, bc, bd, se0);
      total++; if (so !== {16'h0, ds[k]}) begin bad++; $display("FAIL dir%0d_s: got %h want %h", k, so, ds[k]); end
      total++; if (co !== dc[k]) begin bad++; $display("FAIL dir%0d_cout: got %b want %b", k, co, dc[k]); end
      total++; if (inv !== 1'b0) begin bad++; $display("FAIL dir%0d_invalid: got %b want 0", k, inv); end
      total++; if (lat != 5) begin bad++; $display("FAIL dir%0d_latency: got %0d want 5", k, lat); end
      total++; if (bc != 4) begin bad++; $display("FAIL dir%0d_busy_cycles: got %0d want 4", k, bc); end
      total++; if (bd !== 1'b0) begin bad++; $display("FAIL dir%0d_busy_at_done: got %b want 0", k, bd); end
      if (k > 0) begin
        total++; if (se0 !== 32'h0) begin bad++; $display("FAIL dir%0d_s_cleared: got %h want 0", k, se0); end
      end
    end
  endtask

  task automatic test_invalid();
    logic [31:0] so, se0;
    logic co, inv, bd;
    int lat, bc;
    run_op(4, 32'h00A0, 32'h0001, 1'b0, 1'b0, so, co, inv, lat, bc, bd, se0);
    total++; if (inv !== 1'b1) begin bad++; $display("FAIL invalid_set: got %b want 1", inv); end
    total++; if (lat != 5) begin bad++; $display("FAIL invalid_latency: got %0d want 5", lat); end
    repeat (3) @(negedge clk);
    total++; if (inv4 !== 1'b1) begin bad++; $display("FAIL invalid_hold: got %b want 1", inv4); end
    run_op(4, 32'h0002, 32'h0003, 1'b0, 1'b0, so, co, inv, lat, bc, bd, se0);
    total++; if (so !== 32'h0005) begin bad++; $display("FAIL invalid_next_s: got %h want 0005", so); end
    total++; if (inv !== 1'b0) begin bad++; $display("FAIL invalid_next_clear: got %b want 0", inv); end
  endtask

  task automatic test_random();
    logic [31:0] xv, yv, so, se0, s_e;
    logic opv, cv, co, inv, bd, c_e, inv_e;
    int d, lat, bc, pick, pos;
    for (int n = 0; n < 40; n++) begin
      pick = int'($urandom_range(0, 2));
      d = (pick == 0) ? 1 : (pick == 1) ? 4 : 8;
      xv = rand_bcd(d); yv = rand_bcd(d);
      opv = 1'($urandom_range(0, 1)); cv = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        pos = int'($urandom_range(0, d - 1));
        if ($urandom_range(0, 1) == 0) xv[4*pos +: 4] = 4'($urandom_range(10, 15));
        else                           yv[4*pos +: 4] = 4'($urandom_range(10, 15));
      end
      model(d, xv, yv, opv, cv, s_e, c_e, inv_e);
      run_op(d, xv, yv, opv, cv, so, co, inv, lat, bc, bd, se0);
      total++; if (inv !== inv_e) begin bad++; $display("FAIL rnd%0d_invalid d=%0d: got %b want %b", n, d, inv, inv_e); end
      total++; if (lat != d + 1) begin bad++; $display("FAIL rnd%0d_latency d=%0d: got %0d want %0d", n, d, lat, d + 1); end
      if (!inv_e) begin
        total++; if (so !== s_e) begin bad++; $display("FAIL rnd%0d_s d=%0d op=%b x=%h y=%h c=%b: got %h want %h", n, d, opv, xv, yv, cv, so, s_e); end
        total++; if (co !== c_e) begin bad++; $display("FAIL rnd%0d_cout d=%0d op=%b x=%h y=%h c=%b: got %b want %b", n, d, opv, xv, yv, cv, co, c_e); end
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat, extra;
    sel = 4;
    @(negedge clk);
    xb = 32'h1234; yb = 32'h4321; op = 1'b0; c_in = 1'b0; start_v = 3'b010;
    @(posedge clk);
    #1 start_v = 3'b000;
    @(negedge clk);
    @(negedge clk);
    xb = 32'h9999; yb = 32'h9999; op = 1'b1; c_in = 1'b1; start_v = 3'b010;
    @(posedge clk);
    #1 start_v = 3'b000;
    lat = 2;
    while (lat < 40 && !done4) begin
      @(negedge clk);
      lat++;
    end
    total++; if (lat != 5) begin bad++; $display("FAIL ignore_latency: got %0d want 5", lat); end
    total++; if (s4 !== 16'h5555) begin bad++; $display("FAIL ignore_s: got %h want 5555", s4); end
    total++; if (cout4 !== 1'b0) begin bad++; $display("FAIL ignore_cout: got %b want 0", cout4); end
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (busy4 || done4) extra++;
    end
    total++; if (extra != 0) begin bad++; $display("FAIL ignore_no_second_op: got %0d active cycles want 0", extra); end
  endtask

  task automatic test_back_to_back();
    int n, ndone, prev, gap_bad, s_bad;
    sel = 4;
    @(negedge clk);
    xb = 32'h0999; yb = 32'h0001; op = 1'b0; c_in = 1'b0; start_v = 3'b010;
    n = 0; ndone = 0; prev = 0; gap_bad = 0; s_bad = 0;
    while (n < 60 && ndone < 4) begin
      @(negedge clk);
      n++;
      if (done4) begin
        if (ndone == 0) begin
          if (n != 5) gap_bad++;
        end else if (n - prev != 6) gap_bad++;
        if (s4 !== 16'h1000 || cout4 !== 1'b0) s_bad++;
        prev = n;
        ndone++;
      end
    end
    start_v = 3'b000;
    total++; if (ndone != 4) begin bad++; $display("FAIL b2b_count: got %0d want 4", ndone); end
    total++; if (gap_bad != 0) begin bad++; $display("FAIL b2b_spacing: got %0d bad gaps want 0", gap_bad); end
    total++; if (s_bad != 0) begin bad++; $display("FAIL b2b_result: got %0d bad results want 0", s_bad); end
    repeat (2) @(negedge clk);
    total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL b2b_idle_after: got %b want 0", busy4); end
  endtask

  task automatic test_hold();
    logic [31:0] so, se0;
    logic co, inv, bd;
    int lat, bc;
    run_op(4, 32'h0456, 32'h0321, 1'b0, 1'b0, so, co, inv, lat, bc, bd, se0);
    xb = 32'h9999; yb = 32'h9999; op = 1'b1; c_in = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (s4 !== 16'h0777) begin bad++; $display("FAIL hold_s: got %h want 0777", s4); end
    total++; if (cout4 !== 1'b0) begin bad++; $display("FAIL hold_cout: got %b want 0", cout4); end
    total++; if (done4 !== 1'b0) begin bad++; $display("FAIL hold_done: got %b want 0", done4); end
  endtask

  task automatic test_reset_midrun(input int d, input logic [31:0] x1, input logic [31:0] y1,
                                   input logic [31:0] x2, input logic [31:0] y2);
    logic [31:0] so, se0, s_e;
    logic co, inv, bd, c_e, inv_e;
    int lat, bc, seen;
    sel = d;
    @(negedge clk);
    xb = x1; yb = y1; op = 1'b0; c_in = 1'b0; start_v = strb(d);
    @(posedge clk);
    #1 start_v = 3'b000;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    total++; if (busy_m !== 1'b0) begin bad++; $display("FAIL rst%0d_busy: got %b want 0", d, busy_m); end
    total++; if (s_m !== 32'h0) begin bad++; $display("FAIL rst%0d_s: got %h want 0", d, s_m); end
    total++; if (cout_m !== 1'b0) begin bad++; $display("FAIL rst%0d_cout: got %b want 0", d, cout_m); end
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done_m) seen++;
    end
    reset_n = 1'b1;
    repeat (d + 3) begin
      @(negedge clk);
      if (done_m || busy_m) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL rst%0d_no_done: got %0d active cycles want 0", d, seen); end
    model(d, x2, y2, 1'b0, 1'b0, s_e, c_e, inv_e);
    run_op(d, x2, y2, 1'b0, 1'b0, so, co, inv, lat, bc, bd, se0);
    total++; if (so !== s_e) begin bad++; $display("FAIL rst%0d_after_s: got %h want %h", d, so, s_e); end
    total++; if (co !== c_e) begin bad++; $display("FAIL rst%0d_after_cout: got %b want %b", d, co, c_e); end
    total++; if (lat != d + 1) begin bad++; $display("FAIL rst%0d_after_latency: got %0d want %0d", d, lat, d + 1); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_invalid();
    test_ignore_start();
    test_back_to_back();
    test_hold();
    test_random();
    test_reset_midrun(4, 32'h1234, 32'h1111, 32'h0500, 32'h0499);
    test_reset_midrun(1, 32'h0003, 32'h0004, 32'h0009, 32'h0001);
    test_reset_midrun(8, 32'h12345678, 32'h11111111, 32'h99999999, 32'h00000001);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
